// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter and its picker.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Sized for the largest legal N (16); callers zero-extend and truncate.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority picker: first available request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter  int N    = 4,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] rr_ptr,
    input  logic [N-1:0]    exclude,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0]   avail;
    logic [N-1:0]   at_or_above;
    logic [2*N-1:0] dbl;
    int             hit;

    // Low half keeps only bits >= rr_ptr; the upper copy supplies the wrapped-around bits.
    always_comb begin
        avail       = req & ~exclude;
        at_or_above = '0;
        for (int i = 0; i < N; i++) begin
            at_or_above[i] = (i >= int'(rr_ptr));
        end
        dbl   = {avail, avail & at_or_above};
        found = 1'b0;
        hit   = 0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                hit   = i;
            end
        end
        idx = (hit >= N) ? IDXW'(hit - N) : IDXW'(hit);
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// N-way sticky round-robin arbiter with registered one-hot grant.
// Optional forced hand-off after MAX_HOLD cycles is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDXW     = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            preempt
);

    arb_state_t      state;
    logic [IDXW-1:0] rr_ptr;
    logic [N-1:0]    exclude;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [N-1:0]    pick_onehot;
    logic [IDXW-1:0] pick_next_ptr;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int            HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    logic [HCW-1:0] hold_cnt;
`endif

    // The current owner never competes in its own hand-off, so it is visited last.
    assign exclude     = (state == ARB_GRANT) ? grant : '0;
    assign grant_valid = (state == ARB_GRANT);
    assign grant_idx   = IDXW'(onehot_to_idx(16'(grant)));

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .exclude (exclude),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_comb begin
        pick_onehot   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
        pick_next_ptr = (pick_idx == IDXW'(N - 1)) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt <= '0;
            preempt  <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            preempt <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state  <= ARB_GRANT;
                        grant  <= pick_onehot;
                        rr_ptr <= pick_next_ptr;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                ARB_GRANT: begin
                    if (!req[grant_idx]) begin
                        if (pick_found) begin
                            grant  <= pick_onehot;
                            rr_ptr <= pick_next_ptr;
`ifdef RR_ARB_TIMEOUT_EN
                            hold_cnt <= '0;
`endif
                        end else begin
                            state <= ARB_IDLE;
                            grant <= '0;
                        end
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST && pick_found) begin
                        grant    <= pick_onehot;
                        rr_ptr   <= pick_next_ptr;
                        hold_cnt <= '0;
                        preempt  <= 1'b1;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifndef RR_ARB_TIMEOUT_EN
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Randomised and directed checks of rr_grant_arbiter against a behavioural owner/rotation model.
module tb_rr_grant_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDXW     = $clog2(N);

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic            preempt;

    int checks = 0;
    int errors = 0;

    // Model state: current owner (-1 when idle), last owner (-1 after reset), hold length.
    int m_owner = -1;
    int m_last  = -1;
    int m_hold  = 0;
    bit m_preempt = 1'b0;

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .preempt     (preempt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int excl);
        int start;
        start = (m_last + 1) % N;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rn);
        int p;
        m_preempt = 1'b0;
        if (!rn) begin
            m_owner = -1;
            m_last  = -1;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            p = model_pick(r, -1);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_hold  = 0;
            end
        end else if (r[m_owner]) begin
`ifdef RR_ARB_TIMEOUT_EN
            p = model_pick(r, m_owner);
            if (m_hold == MAX_HOLD - 1 && p >= 0) begin
                m_owner   = p;
                m_last    = p;
                m_hold    = 0;
                m_preempt = 1'b1;
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
`else
            m_hold++;
`endif
        end else begin
            p = model_pick(r, m_owner);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_hold  = 0;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic rn);
        logic [N-1:0] exp_grant;
        @(negedge clock);
        req     = r;
        reset_n = rn;
        model_step(r, rn);
        @(posedge clock);
        #1;
        exp_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
        checkOutput("grant", 32'(grant), 32'(exp_grant));
        checkOutput("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        checkOutput("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        checkOutput("preempt", 32'(preempt), 32'(m_preempt));
    endtask

    initial begin
        logic [N-1:0] r;

        // Reset held with every requester asserted.
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("reset_grant_const", 32'(grant), 32'd0);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("first_grant_const", 32'(grant), 32'b0001);

        // Rotation: each owner holds two cycles then drops its bit for one.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 1'b1);
            applyStimulus(4'b1111, 1'b1);
            r = 4'b1111;
            r[m_owner] = 1'b0;
            applyStimulus(r, 1'b1);
        end

        // Sticky hold against a competing requester, then release.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        for (int k = 0; k < 50; k++) applyStimulus(4'b0011, 1'b1);
        applyStimulus(4'b0010, 1'b1);

        // Idle gap and pointer wrap through requester 3.
        applyStimulus(4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(4'b1000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0001, 1'b1);

        // Reset while requester 2 owns the grant.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("owner2_const", 32'(grant), 32'b0100);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("midreset_const", 32'(grant), 32'd0);
        applyStimulus(4'b0101, 1'b1);
        checkOutput("post_reset_const", 32'(grant), 32'b0001);

        // Long contention and lone requester; exercises forced hand-off when enabled.
        for (int k = 0; k < 20; k++) applyStimulus(4'b0011, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        for (int k = 0; k < 20; k++) applyStimulus(4'b0001, 1'b1);

        // Random traffic biased toward owners keeping their request.
        for (int k = 0; k < 400; k++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            if (m_owner >= 0 && ($urandom % 4) != 0) r[m_owner] = 1'b1;
            applyStimulus(r, ($urandom % 50) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
